// File: rtl/scr1_tb_ahb_mem_pkg.sv
// Shared definitions for the multi-port AHB-Lite test memory.
// Holds the per-port FSM state encoding, AHB HTRANS/HSIZE codes, the
// random-stall LFSR polynomial/seed and the all-ones random-stall code,
// plus small helpers for byte-lane selection and LFSR stepping.
// Random stall is enabled by defining SCR1_TB_AHB_MEM_RAND_STALL_EN.
package scr1_tb_ahb_mem_pkg;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_WAIT,
    PORT_ERR1,
    PORT_ERR2
  } port_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // stall_cfg equal to all ones (truncated to STALL_W) selects random stall
  localparam logic [31:0] RAND_STALL_CODE = '1;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << lo;
      HSIZE_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

  // Galois form: shift right, fold the polynomial in when bit 0 falls out
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/scr1_tb_ahb_mem_if.sv
// AHB-Lite bus bundle for PORTS_NUM independent ports, each field packed
// port-major (port p occupies slice [p*W +: W]).
// master: drives htrans/haddr/hsize/hwrite/hwdata, receives hready/hrdata/hresp.
// slave:  the memory side.
interface scr1_tb_ahb_mem_if #(
  parameter int unsigned PORTS_NUM = 2
);
  logic [PORTS_NUM*2-1:0]  htrans;
  logic [PORTS_NUM*32-1:0] haddr;
  logic [PORTS_NUM*3-1:0]  hsize;
  logic [PORTS_NUM-1:0]    hwrite;
  logic [PORTS_NUM*32-1:0] hwdata;
  logic [PORTS_NUM-1:0]    hready;
  logic [PORTS_NUM*32-1:0] hrdata;
  logic [PORTS_NUM-1:0]    hresp;

  modport master (
    output htrans, haddr, hsize, hwrite, hwdata,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  htrans, haddr, hsize, hwrite, hwdata,
    output hready, hrdata, hresp
  );
endinterface

// File: rtl/scr1_tb_ahb_mem_port.sv
// One AHB-Lite slave port controller: IDLE/WAIT/ERR1/ERR2 FSM, wait-state
// counter and (with SCR1_TB_AHB_MEM_RAND_STALL_EN) a random-stall LFSR.
// Ports:
//   clk, rst        clock, async active-high reset
//   stall_cfg       wait-state count sampled at address-phase acceptance
//   htrans/haddr/hsize/hwrite  this port's address-phase signals
//   hready, hresp   this port's response
//   dp_done         data phase completes this cycle (legal transfer)
//   dp_write        latched transfer direction
//   dp_widx, dp_be  latched word index and byte lanes
module scr1_tb_ahb_mem_port
  import scr1_tb_ahb_mem_pkg::*;
#(
  parameter int unsigned MEM_POWER_SIZE = 20,
  parameter int unsigned STALL_W        = 8
`ifdef SCR1_TB_AHB_MEM_RAND_STALL_EN
  ,
  parameter int unsigned PORT_IDX       = 0
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_W-1:0]        stall_cfg,
  input  logic [1:0]                htrans,
  input  logic [31:0]               haddr,
  input  logic [2:0]                hsize,
  input  logic                      hwrite,
  output logic                      hready,
  output logic                      hresp,
  output logic                      dp_done,
  output logic                      dp_write,
  output logic [MEM_POWER_SIZE-3:0] dp_widx,
  output logic [3:0]                dp_be
);

  port_state_e               state_q, state_d;
  logic [STALL_W-1:0]        cnt_q, cnt_d;
  logic [MEM_POWER_SIZE-1:0] addr_q;
  logic [2:0]                size_q;
  logic                      write_q;
  logic                      accept;
  logic                      err;
  logic [STALL_W-1:0]        stall_sel;

`ifdef SCR1_TB_AHB_MEM_RAND_STALL_EN
  logic [15:0] lfsr_q;

  always_comb begin
    stall_sel = stall_cfg;
    if (stall_cfg == RAND_STALL_CODE[STALL_W-1:0]) begin
      stall_sel = STALL_W'(lfsr_q[2:0]);
    end
  end
`else
  always_comb stall_sel = stall_cfg;
`endif

  always_comb begin
    err = (|haddr[31:MEM_POWER_SIZE])
       || (hsize > HSIZE_WORD)
       || ((hsize == HSIZE_HALF) && haddr[0])
       || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
  end

  always_comb begin
    hready   = 1'b0;
    hresp    = 1'b0;
    dp_done  = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      PORT_IDLE: hready = 1'b1;
      PORT_WAIT: begin
        if (cnt_q == '0) begin
          hready  = 1'b1;
          dp_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PORT_ERR1: begin
        hresp   = 1'b1;
        state_d = PORT_ERR2;
      end
      PORT_ERR2: begin
        hready = 1'b1;
        hresp  = 1'b1;
      end
      default: state_d = PORT_IDLE;
    endcase

    accept = htrans[1] && hready;
    // Any hready=1 cycle ends the current transfer; a new one accepted in
    // the same cycle starts its data phase immediately.
    if (accept) begin
      state_d = err ? PORT_ERR1 : PORT_WAIT;
      cnt_d   = err ? '0 : stall_sel;
    end else if (hready) begin
      state_d = PORT_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PORT_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= haddr[MEM_POWER_SIZE-1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

`ifdef SCR1_TB_AHB_MEM_RAND_STALL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED + 16'(PORT_IDX);
    end else if (accept) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end
`endif

  assign dp_write = write_q;
  assign dp_widx  = addr_q[MEM_POWER_SIZE-1:2];
  assign dp_be    = byte_en(size_q, addr_q[1:0]);

endmodule

// File: rtl/scr1_tb_ahb_mem_mp.sv
// Multi-port AHB-Lite test memory: 2**MEM_POWER_SIZE bytes of 32-bit words
// shared by PORTS_NUM independent slave ports with configurable wait states.
// Random stall (stall_cfg all ones) is enabled by SCR1_TB_AHB_MEM_RAND_STALL_EN.
// Ports:
//   clk, rst   clock, async active-high reset (memory contents kept)
//   stall_cfg  per-port wait-state count, PORTS_NUM*STALL_W
//   ahb        slave side of the AHB bundle (htrans/haddr/hsize/hwrite/
//              hwdata in, hready/hrdata/hresp out)
module scr1_tb_ahb_mem_mp
  import scr1_tb_ahb_mem_pkg::*;
#(
  parameter int unsigned PORTS_NUM      = 2,
  parameter int unsigned MEM_POWER_SIZE = 20,
  parameter int unsigned STALL_W        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS_NUM*STALL_W-1:0] stall_cfg,
  scr1_tb_ahb_mem_if.slave             ahb
);

  localparam int unsigned WORDS = 2 ** (MEM_POWER_SIZE - 2);

  logic [31:0] mem [WORDS];

  logic                      hready_a [PORTS_NUM];
  logic                      hresp_a  [PORTS_NUM];
  logic                      done_a   [PORTS_NUM];
  logic                      write_a  [PORTS_NUM];
  logic [MEM_POWER_SIZE-3:0] widx_a   [PORTS_NUM];
  logic [3:0]                be_a     [PORTS_NUM];

  for (genvar p = 0; p < PORTS_NUM; p++) begin : g_port
    scr1_tb_ahb_mem_port #(
      .MEM_POWER_SIZE (MEM_POWER_SIZE),
      .STALL_W        (STALL_W)
`ifdef SCR1_TB_AHB_MEM_RAND_STALL_EN
      ,
      .PORT_IDX       (p)
`endif
    ) u_port (
      .clk       (clk),
      .rst       (rst),
      .stall_cfg (stall_cfg[p*STALL_W +: STALL_W]),
      .htrans    (ahb.htrans[p*2 +: 2]),
      .haddr     (ahb.haddr[p*32 +: 32]),
      .hsize     (ahb.hsize[p*3 +: 3]),
      .hwrite    (ahb.hwrite[p]),
      .hready    (hready_a[p]),
      .hresp     (hresp_a[p]),
      .dp_done   (done_a[p]),
      .dp_write  (write_a[p]),
      .dp_widx   (widx_a[p]),
      .dp_be     (be_a[p])
    );
  end

  // Reads see the array before this edge's writes, so a same-cycle
  // read/write collision returns the old word.
  always_comb begin
    ahb.hready = '0;
    ahb.hresp  = '0;
    ahb.hrdata = '0;
    for (int unsigned i = 0; i < PORTS_NUM; i++) begin
      ahb.hready[i] = hready_a[i];
      ahb.hresp[i]  = hresp_a[i];
      if (done_a[i] && !write_a[i]) begin
        ahb.hrdata[i*32 +: 32] = mem[widx_a[i]];
      end
    end
  end

  // Ports are visited highest index first so the lowest-index writer's
  // lane assignment is the last one scheduled and wins per byte.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PORTS_NUM; i++) begin
      if (done_a[PORTS_NUM-1-i] && write_a[PORTS_NUM-1-i]) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (be_a[PORTS_NUM-1-i][b]) begin
            mem[widx_a[PORTS_NUM-1-i]][b*8 +: 8] <=
              ahb.hwdata[(PORTS_NUM-1-i)*32 + b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scr1_tb_ahb_mem_mp.sv
module tb_scr1_tb_ahb_mem_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] stall_cfg;

  scr1_tb_ahb_mem_if #(.PORTS_NUM(2)) bus ();

  scr1_tb_ahb_mem_mp #(
    .PORTS_NUM      (2),
    .MEM_POWER_SIZE (20),
    .STALL_W        (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_cfg (stall_cfg),
    .ahb       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  int          lows;
  logic        r_first, r_last;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_ph(input int p, input logic wr, input logic [2:0] sz, input logic [31:0] a);
    bus.htrans[p*2 +: 2] = 2'b10;
    bus.haddr[p*32 +: 32] = a;
    bus.hsize[p*3 +: 3] = sz;
    bus.hwrite[p] = wr;
  endtask

  task automatic idle_ph(input int p);
    bus.htrans[p*2 +: 2] = 2'b00;
  endtask

  // Single non-pipelined transfer; stall_after is written to stall_cfg
  // right after acceptance.
  task automatic xfer(input int p, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [7:0] stall_after,
                      output logic [31:0] o_rd, output int o_lows,
                      output logic o_first, output logic o_last);
    addr_ph(p, wr, sz, a);
    cyc();
    idle_ph(p);
    bus.hwdata[p*32 +: 32] = wd;
    stall_cfg[p*8 +: 8] = stall_after;
    o_lows = 0;
    o_first = bus.hresp[p];
    while (bus.hready[p] !== 1'b1 && o_lows < 400) begin
      o_lows++;
      cyc();
    end
    o_rd = bus.hrdata[p*32 +: 32];
    o_last = bus.hresp[p];
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    total++; if (bus.hready !== 2'b11) begin bad++; $display("FAIL reset_hready: got %b want 11", bus.hready); end
    total++; if (bus.hresp !== 2'b00) begin bad++; $display("FAIL reset_hresp: got %b want 00", bus.hresp); end
    total++; if (bus.hrdata !== 64'h0) begin bad++; $display("FAIL reset_hrdata: got %h want 0", bus.hrdata); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    stall_cfg[7:0] = 8'd0;
    addr_ph(0, 1'b1, 3'd2, 32'h100);
    cyc();
    total++; if (bus.hready[0] !== 1'b1) begin bad++; $display("FAIL b2b_wr_hready: got %b want 1", bus.hready[0]); end
    bus.hwdata[31:0] = 32'hDEADBEEF;
    addr_ph(0, 1'b0, 3'd2, 32'h100);
    cyc();
    idle_ph(0);
    total++; if (bus.hready[0] !== 1'b1) begin bad++; $display("FAIL b2b_rd_hready: got %b want 1", bus.hready[0]); end
    total++; if (bus.hrdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_rd_data: got %h want deadbeef", bus.hrdata[31:0]); end
    total++; if (bus.hresp[0] !== 1'b0) begin bad++; $display("FAIL b2b_rd_resp: got %b want 0", bus.hresp[0]); end
    cyc();
  endtask

  task automatic test_stall();
    stall_cfg[15:8] = 8'd3;
    xfer(1, 1'b1, 3'd0, 32'h103, 32'h5A000000, 8'd3, rd, lows, r_first, r_last);
    total++; if (lows !== 3) begin bad++; $display("FAIL stall_byte_wr_lows: got %0d want 3", lows); end
    total++; if (r_last !== 1'b0) begin bad++; $display("FAIL stall_byte_wr_resp: got %b want 0", r_last); end
    xfer(1, 1'b0, 3'd2, 32'h100, 32'h0, 8'd3, rd, lows, r_first, r_last);
    total++; if (lows !== 3) begin bad++; $display("FAIL stall_rd_lows: got %0d want 3", lows); end
    total++; if (rd !== 32'h5AADBEEF) begin bad++; $display("FAIL stall_rd_data: got %h want 5aadbeef", rd); end
    // halfword lane placement
    stall_cfg[7:0] = 8'd0;
    xfer(0, 1'b1, 3'd2, 32'h108, 32'h01020304, 8'd0, rd, lows, r_first, r_last);
    xfer(0, 1'b1, 3'd1, 32'h10A, 32'hCAFE0000, 8'd0, rd, lows, r_first, r_last);
    xfer(0, 1'b0, 3'd2, 32'h108, 32'h0, 8'd0, rd, lows, r_first, r_last);
    total++; if (rd !== 32'hCAFE0304) begin bad++; $display("FAIL half_wr_data: got %h want cafe0304", rd); end
  endtask

  task automatic test_stall_sample();
    stall_cfg[15:8] = 8'd4;
    xfer(1, 1'b1, 3'd2, 32'h180, 32'h0BADF00D, 8'd0, rd, lows, r_first, r_last);
    total++; if (lows !== 4) begin bad++; $display("FAIL stall_sample_a: got %0d want 4", lows); end
    xfer(1, 1'b0, 3'd2, 32'h180, 32'h0, 8'd6, rd, lows, r_first, r_last);
    total++; if (lows !== 0) begin bad++; $display("FAIL stall_sample_b: got %0d want 0", lows); end
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL stall_sample_data: got %h want 0badf00d", rd); end
    stall_cfg[15:8] = 8'd0;
  endtask

  task automatic test_errors();
    stall_cfg[7:0] = 8'd0;
    xfer(0, 1'b0, 3'd2, 32'h102, 32'h0, 8'd0, rd, lows, r_first, r_last);
    total++; if ({lows == 1, r_first, r_last} !== 3'b111) begin bad++; $display("FAIL err_misalign_rd: lows=%0d first=%b last=%b want 1/1/1", lows, r_first, r_last); end
    xfer(0, 1'b0, 3'd2, 32'h00100000, 32'h0, 8'd0, rd, lows, r_first, r_last);
    total++; if ({lows == 1, r_first, r_last} !== 3'b111) begin bad++; $display("FAIL err_range_rd: lows=%0d first=%b last=%b want 1/1/1", lows, r_first, r_last); end
    xfer(0, 1'b1, 3'd1, 32'h101, 32'hFFFFFFFF, 8'd0, rd, lows, r_first, r_last);
    total++; if ({lows == 1, r_first, r_last} !== 3'b111) begin bad++; $display("FAIL err_half_wr: lows=%0d first=%b last=%b want 1/1/1", lows, r_first, r_last); end
    xfer(0, 1'b1, 3'd3, 32'h100, 32'hFFFFFFFF, 8'd0, rd, lows, r_first, r_last);
    total++; if ({lows == 1, r_first, r_last} !== 3'b111) begin bad++; $display("FAIL err_size_wr: lows=%0d first=%b last=%b want 1/1/1", lows, r_first, r_last); end
    xfer(0, 1'b0, 3'd2, 32'h100, 32'h0, 8'd0, rd, lows, r_first, r_last);
    total++; if (rd !== 32'h5AADBEEF) begin bad++; $display("FAIL err_mem_unchanged: got %h want 5aadbeef", rd); end
    stall_cfg[15:8] = 8'd3;
    xfer(1, 1'b0, 3'd0, 32'h00200000, 32'h0, 8'd3, rd, lows, r_first, r_last);
    total++; if ({lows == 1, r_first, r_last} !== 3'b111) begin bad++; $display("FAIL err_no_stall: lows=%0d first=%b last=%b want 1/1/1", lows, r_first, r_last); end
    stall_cfg[15:8] = 8'd0;
    xfer(0, 1'b1, 3'd2, 32'h000FFFFC, 32'hA5A5A5A5, 8'd0, rd, lows, r_first, r_last);
    total++; if ({lows == 0, r_last} !== 2'b10) begin bad++; $display("FAIL top_word_wr: lows=%0d resp=%b want 0/0", lows, r_last); end
    xfer(1, 1'b0, 3'd2, 32'h000FFFFC, 32'h0, 8'd0, rd, lows, r_first, r_last);
    total++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL top_word_rd: got %h want a5a5a5a5", rd); end
  endtask

  task automatic test_same_cycle();
    stall_cfg = 16'h0000;
    addr_ph(0, 1'b1, 3'd2, 32'h200);
    addr_ph(1, 1'b1, 3'd2, 32'h200);
    cyc();
    idle_ph(0); idle_ph(1);
    bus.hwdata = {32'h22222222, 32'h11111111};
    total++; if (bus.hready !== 2'b11) begin bad++; $display("FAIL same_wr_hready: got %b want 11", bus.hready); end
    cyc();
    addr_ph(0, 1'b1, 3'd0, 32'h204);
    addr_ph(1, 1'b1, 3'd2, 32'h204);
    cyc();
    idle_ph(0); idle_ph(1);
    bus.hwdata = {32'h22222222, 32'h000000AA};
    cyc();
    xfer(1, 1'b0, 3'd2, 32'h200, 32'h0, 8'd0, rd, lows, r_first, r_last);
    total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL same_word_prio: got %h want 11111111", rd); end
    xfer(1, 1'b0, 3'd2, 32'h204, 32'h0, 8'd0, rd, lows, r_first, r_last);
    total++; if (rd !== 32'h222222AA) begin bad++; $display("FAIL same_lane_prio: got %h want 222222aa", rd); end
    addr_ph(0, 1'b1, 3'd2, 32'h200);
    addr_ph(1, 1'b0, 3'd2, 32'h200);
    cyc();
    idle_ph(0); idle_ph(1);
    bus.hwdata[31:0] = 32'h33333333;
    total++; if (bus.hrdata[63:32] !== 32'h11111111) begin bad++; $display("FAIL rd_wr_collide: got %h want 11111111", bus.hrdata[63:32]); end
    cyc();
    xfer(1, 1'b0, 3'd2, 32'h200, 32'h0, 8'd0, rd, lows, r_first, r_last);
    total++; if (rd !== 32'h33333333) begin bad++; $display("FAIL rd_after_collide: got %h want 33333333", rd); end
  endtask

  task automatic test_reset_mid();
    stall_cfg[7:0] = 8'd0;
    xfer(0, 1'b1, 3'd2, 32'h300, 32'h12345678, 8'd0, rd, lows, r_first, r_last);
    stall_cfg[7:0] = 8'd5;
    addr_ph(0, 1'b1, 3'd2, 32'h300);
    cyc();
    idle_ph(0);
    bus.hwdata[31:0] = 32'hCAFEF00D;
    total++; if (bus.hready[0] !== 1'b0) begin bad++; $display("FAIL rstmid_stall1: got %b want 0", bus.hready[0]); end
    cyc();
    rst = 1'b1;
    #1;
    total++; if ({bus.hready[0], bus.hresp[0]} !== 2'b10) begin bad++; $display("FAIL rstmid_resp: got %b want 10", {bus.hready[0], bus.hresp[0]}); end
    total++; if (bus.hrdata !== 64'h0) begin bad++; $display("FAIL rstmid_hrdata: got %h want 0", bus.hrdata); end
    cyc();
    cyc();
    rst = 1'b0;
    stall_cfg[7:0] = 8'd0;
    cyc();
    xfer(0, 1'b0, 3'd2, 32'h300, 32'h0, 8'd0, rd, lows, r_first, r_last);
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL rstmid_mem: got %h want 12345678", rd); end
  endtask

  task automatic test_rand_stall();
`ifdef SCR1_TB_AHB_MEM_RAND_STALL_EN
    logic [15:0] lf;
    logic [7:0]  seen;
    int          distinct;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    stall_cfg[7:0] = 8'hFF;
    lf = 16'hACE1;
    seen = '0;
    for (int i = 0; i < 100; i++) begin
      xfer(0, 1'b0, 3'd2, 32'h100, 32'h0, 8'hFF, rd, lows, r_first, r_last);
      total++; if (lows !== int'(lf[2:0])) begin bad++; $display("FAIL rand_stall_%0d: got %0d want %0d", i, lows, lf[2:0]); end
      if (lows >= 0 && lows < 8) seen[lows] = 1'b1;
      lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0000);
    end
    distinct = 0;
    for (int i = 0; i < 8; i++) distinct += int'(seen[i]);
    total++; if (distinct < 4) begin bad++; $display("FAIL rand_distinct: got %0d want >=4", distinct); end
`else
    stall_cfg[7:0] = 8'hFF;
    xfer(0, 1'b0, 3'd2, 32'h100, 32'h0, 8'hFF, rd, lows, r_first, r_last);
    total++; if (lows !== 255) begin bad++; $display("FAIL literal_ff_stall: got %0d want 255", lows); end
    total++; if (rd !== 32'h5AADBEEF) begin bad++; $display("FAIL literal_ff_data: got %h want 5aadbeef", rd); end
`endif
    stall_cfg[7:0] = 8'd0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    stall_cfg  = 16'h0000;
    bus.htrans = '0;
    bus.haddr  = '0;
    bus.hsize  = '0;
    bus.hwrite = '0;
    bus.hwdata = '0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_stall_sample();
    test_errors();
    test_same_cycle();
    test_reset_mid();
    test_rand_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scr1_tb_ahb_mem_mp.md
SCR1_TB_AHB_MEM_MP -- requirements
Module: scr1_tb_ahb_mem_mp

Interface
REQ-001 Parameter PORTS_NUM, default 2: number of independent AHB-Lite slave ports, range 1..4.
REQ-002 Parameter MEM_POWER_SIZE, default 20: memory is 2**MEM_POWER_SIZE bytes, word-organised, 32-bit.
REQ-003 Parameter STALL_W, default 8: width of per-port stall configuration.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 stall_cfg  in  PORTS_NUM*STALL_W  per-port wait-state count, or random-stall enable (REQ-020).
REQ-007 htrans  in  PORTS_NUM*2  AHB transfer type per port.
REQ-008 haddr  in  PORTS_NUM*32  AHB address per port.
REQ-009 hsize  in  PORTS_NUM*3  AHB size per port: 0 byte, 1 half, 2 word; other values are errors.
REQ-010 hwrite  in  PORTS_NUM  AHB write flag per port.
REQ-011 hwdata  in  PORTS_NUM*32  AHB write data per port, data phase.
REQ-012 hready  out  PORTS_NUM  transfer-done per port.
REQ-013 hrdata  out  PORTS_NUM*32  read data per port, valid when hready=1 in a read data phase.
REQ-014 hresp  out  PORTS_NUM  per port: 0 OKAY, 1 ERROR.

Function
REQ-015 Each port shall run its own FSM, with states IDLE, WAIT, ERR1 and ERR2; hready=1 in IDLE.
REQ-016 The address phase shall be accepted when htrans[1]=1 (NONSEQ/SEQ) and hready=1; haddr, hsize and hwrite are latched on that edge; IDLE/BUSY transfers are ignored.
REQ-017 An accepted legal transfer with stall count k shall hold hready=0 for exactly k cycles, then drive hready=1, hresp=0; with k=0 the data phase completes in the first cycle.
REQ-018 Reads shall return the aligned word at haddr[MEM_POWER_SIZE-1:2] on all byte lanes.
REQ-019 Writes shall apply hwdata on the hready=1 data-phase edge, updating only the byte lanes selected by hsize/haddr[1:0].
REQ-020 When stall_cfg for a port is all ones, that port shall use random stall 0..7 cycles per transfer; this applies only with the REQ-029 macro defined, and otherwise the value is a literal count.
REQ-021 Error conditions are: address >= 2**MEM_POWER_SIZE; a misaligned half or word access; or hsize > 2.
REQ-022 On an error condition, the port shall give a two-cycle response: ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), with no stall inserted and no memory write.
REQ-023 A new address phase accepted in the completing cycle shall start its data phase back-to-back with no idle cycle.
REQ-024 For same-cycle writes to the same word, per byte lane the lowest-index port shall win.
REQ-025 A read and a write to the same word in the same cycle shall return the pre-write data.
REQ-026 stall_cfg shall be sampled at address-phase acceptance; a change mid-transfer shall not affect that transfer.

Reset
REQ-027 While rst=1, every FSM shall be in IDLE with hready=1, hresp=0 and hrdata=0, the stall counters and LFSRs shall hold their reset values, and memory contents shall be unchanged.
REQ-028 When rst asserts mid-transfer, the pending transfer shall be abandoned, its write dropped and the FSM returned to IDLE.

Configuration
REQ-029 Macro SCR1_TB_AHB_MEM_RAND_STALL_EN shall control random stall.
- Defined: each port has a 16-bit Galois LFSR (poly 0xB400, seed 0xACE1 + port index) that advances once per accepted transfer, and bits [2:0] give the stall.
- Undefined: the LFSR is absent and stall_cfg is always a literal count.

Structure
REQ-030 Package scr1_tb_ahb_mem_pkg shall hold the FSM state enum, HTRANS/HSIZE constants, the LFSR polynomial/seed and the all-ones random-stall code.
REQ-031 The per-port FSM, stall counter and LFSR shall be sub-module scr1_tb_ahb_mem_port, instantiated PORTS_NUM times; the memory array and write-lane resolution shall stay in the top.

Verification
REQ-032 Port0, stall 0: word write 0xDEADBEEF @0x100, then read @0x100 → hready never low; hrdata=0xDEADBEEF in the read data phase.
REQ-033 Port1, stall 3: byte write 0x5A @0x103, then word read @0x100 → 3 hready-low cycles per transfer; read returns 0x5AADBEEF.
REQ-034 Word read @0x102, then read @0x00100000 with MEM_POWER_SIZE=20 → each gives ERR1/ERR2 (hresp=1 for 2 cycles, hready 0 then 1); memory unchanged.
REQ-035 Ports 0 and 1 same-cycle word write @0x200 with 0x11111111 and 0x22222222 → later read gives 0x11111111.
REQ-036 rst asserted during stall cycle 2 of 5 of a write @0x300 → hready=1 immediately; word @0x300 unchanged after release.
REQ-037 Macro defined, stall_cfg=0xFF, 100 back-to-back reads → every stall in 0..7, sequence reproducible across runs, at least 4 distinct values.
